// File: rtl/alu_bist.sv
// Self-test engine for the 16-bit add/sub ALU: drives eight hardwired vectors,
// checks OUT/ZERO against a golden model and reports pass, first failure and error count.
module alu_bist #(
  parameter int WIDTH       = 16,
  parameter int NUM_VECTORS = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic [WIDTH-1:0] ALU_SRCA,
  output logic [WIDTH-1:0] ALU_SRCB,
  output logic             ALU_OP,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_ZERO,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [2:0]       FAIL_INDEX,
  output logic [3:0]       ERR_COUNT,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_idx;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic             r_op;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [2:0]       r_fail_index;
  logic [3:0]       r_err_count;

  logic             w_accept;
  logic             w_sample;
  logic             w_last;
  logic             w_load;
  logic [2:0]       w_load_idx;
  logic [WIDTH-1:0] w_exp;
  logic             w_fail;
  logic [WIDTH-1:0] w_vec_a;
  logic [WIDTH-1:0] w_vec_b;
  logic             w_vec_op;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (START) w_next_state = S_DRIVE;
      S_DRIVE:  w_next_state = S_SAMPLE;
      S_SAMPLE: w_next_state = w_last ? S_FINISH : S_DRIVE;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output/control decode; the golden model works on the registered operands
  always_comb begin
    w_accept   = (r_state == S_IDLE) && START;
    w_sample   = (r_state == S_SAMPLE);
    w_last     = (r_idx == 3'(NUM_VECTORS - 1));
    w_load     = w_accept || (w_sample && !w_last);
    w_load_idx = w_accept ? 3'd0 : 3'(r_idx + 3'd1);
    w_exp      = r_op ? (r_srca - r_srcb) : (r_srca + r_srcb);
    w_fail     = w_sample && ((ALU_OUT != w_exp) || (ALU_ZERO != (w_exp == '0)));
  end

  // Hardwired vector table (A, B, OP); OP 1 = subtract
  always_comb begin
    w_vec_a  = WIDTH'(5);
    w_vec_b  = WIDTH'(5);
    w_vec_op = 1'b0;
    case (w_load_idx)
      3'd0: begin w_vec_a = WIDTH'(5);  w_vec_b = WIDTH'(5);  w_vec_op = 1'b0; end
      3'd1: begin w_vec_a = WIDTH'(5);  w_vec_b = WIDTH'(-3); w_vec_op = 1'b0; end
      3'd2: begin w_vec_a = WIDTH'(-5); w_vec_b = WIDTH'(-3); w_vec_op = 1'b0; end
      3'd3: begin w_vec_a = WIDTH'(5);  w_vec_b = WIDTH'(-4); w_vec_op = 1'b1; end
      3'd4: begin w_vec_a = WIDTH'(5);  w_vec_b = WIDTH'(-3); w_vec_op = 1'b1; end
      3'd5: begin w_vec_a = WIDTH'(-5); w_vec_b = WIDTH'(-3); w_vec_op = 1'b1; end
      3'd6: begin w_vec_a = WIDTH'(5);  w_vec_b = WIDTH'(-5); w_vec_op = 1'b0; end
      3'd7: begin w_vec_a = WIDTH'(5);  w_vec_b = WIDTH'(5);  w_vec_op = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx        <= '0;
      r_srca       <= '0;
      r_srcb       <= '0;
      r_op         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_index <= '0;
      r_err_count  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy       <= 1'b1;
        r_pass       <= 1'b0;
        r_fail_index <= '0;
        r_err_count  <= '0;
      end
      if (w_load) begin
        r_idx  <= w_load_idx;
        r_srca <= w_vec_a;
        r_srcb <= w_vec_b;
        r_op   <= w_vec_op;
      end
      if (w_fail) begin
        if (r_err_count != 4'hF) r_err_count  <= r_err_count + 4'd1;
        if (r_err_count == 4'd0) r_fail_index <= r_idx;
      end
      // A nonzero error count can only come from an earlier vector of this run
      if (w_sample && w_last) begin
        r_pass <= !w_fail && (r_err_count == 4'd0);
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign ALU_SRCA   = r_srca;
  assign ALU_SRCB   = r_srcb;
  assign ALU_OP     = r_op;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign PASS       = r_pass;
  assign FAIL_INDEX = r_fail_index;
  assign ERR_COUNT  = r_err_count;
  assign DBG_STATE  = r_state;

endmodule
